rr_arbiter_4: RTL

Four-input round-robin arbiter that shares one downstream FIFO write port between four upstream FIFOs. Each cycle it selects one non-empty upstream FIFO, pops a single word from it and registers that word onto the shared output with a push strobe. It honours downstream back-pressure. It sits between the per-lane input FIFOs and the common output FIFO of the lane-merging datapath, which is built from the team's DFF/DFFSR and gate cells.

---
 rtl/rr_arbiter_4.sv | 113 +++++++++++
 1 files changed

// File: rtl/rr_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_4
// Purpose  : Four-lane round-robin arbiter. It pops one word per cycle from a
//            non-empty upstream FIFO and registers that word onto a single
//            downstream FIFO write port. It stalls while the downstream
//            FIFO is almost full.
// Ports    : clk             - system clock, rising edge
//            reset_L         - asynchronous reset, active low
//            fifo_empty[3:0] - upstream empty flags (0 = lane requesting)
//            data_in         - show-ahead data, lane i at [i*DW +: DW]
//            out_almost_full - downstream almost-full; blocks new pops
//            pop[3:0]        - one-hot/zero pop strobes (combinational)
//            push_out        - downstream write strobe (registered)
//            data_out        - downstream write data (registered)
//            state[1:0]      - 00 INIT, 01 IDLE, 10 ACTIVE, 11 PAUSED
//            words_fwd[7:0]  - forwarded-word counter, wraps mod 256
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter_4 #(
    parameter int DATA_WIDTH = 6
) (
    input  logic                    clk,
    input  logic                    reset_L,
    input  logic [3:0]              fifo_empty,
    input  logic [4*DATA_WIDTH-1:0] data_in,
    input  logic                    out_almost_full,
    output logic [3:0]              pop,
    output logic                    push_out,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic [1:0]              state,
    output logic [7:0]              words_fwd
);

    localparam logic [1:0] c_ST_INIT   = 2'b00;
    localparam logic [1:0] c_ST_IDLE   = 2'b01;
    localparam logic [1:0] c_ST_ACTIVE = 2'b10;
    localparam logic [1:0] c_ST_PAUSED = 2'b11;

    logic [1:0]            r_state;
    logic                  r_push;
    logic [DATA_WIDTH-1:0] r_data;
    logic [7:0]            r_words;
    logic [1:0]            r_last;

    logic [3:0]            w_req;
    logic                  w_found;
    logic [1:0]            w_grant;
    logic                  w_valid;
    logic [DATA_WIDTH-1:0] w_sel;
    logic [1:0]            w_state_nxt;

    assign w_req = ~fifo_empty;

    // Search lanes last+1, last+2, last+3, last (2-bit wrap). The first hit wins.
    always_comb begin
        w_found = 1'b0;
        w_grant = r_last;
        for (int k = 1; k <= 4; k++) begin
            if (!w_found && w_req[r_last + 2'(k)]) begin
                w_found = 1'b1;
                w_grant = r_last + 2'(k);
            end
        end
    end

    // reset_L is in the qualifier so that pop drops as soon as reset is asserted.
    // The pop of an interrupted cycle is withdrawn together with its push.
    assign w_valid = w_found && !out_almost_full && reset_L && (r_state != c_ST_INIT);

    assign pop   = w_valid ? (4'b0001 << w_grant) : 4'b0000;
    assign w_sel = data_in[int'(w_grant)*DATA_WIDTH +: DATA_WIDTH];

    // A non-zero request with no valid grant outside INIT can only mean
    // that back-pressure is active.
    always_comb begin
        w_state_nxt = c_ST_IDLE;
        if (r_state == c_ST_INIT) begin
            w_state_nxt = c_ST_IDLE;
        end else if (w_valid) begin
            w_state_nxt = c_ST_ACTIVE;
        end else if (w_req != 4'b0000) begin
            w_state_nxt = c_ST_PAUSED;
        end else begin
            w_state_nxt = c_ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= c_ST_INIT;
            r_push  <= 1'b0;
            r_data  <= '0;
            r_words <= 8'd0;
            r_last  <= 2'd3;   // lane 0 is searched first after reset
        end else begin
            r_state <= w_state_nxt;
            r_push  <= w_valid;
            if (w_valid) begin
                r_data  <= w_sel;
                r_last  <= w_grant;
                r_words <= r_words + 8'd1;
            end
        end
    end

    assign push_out  = r_push;
    assign data_out  = r_data;
    assign state     = r_state;
    assign words_fwd = r_words;

endmodule
`default_nettype wire
